jk_excite_gen: RTL

- Drives a JK flip-flop. It is the inverse of the JK characteristic table: it takes a stream of target Q bits and produces the J/K excitation that moves the flip-flop to each target.
- It checks the flip-flop's Q feedback against its own prediction and counts mismatches.
- It sits upstream of the jk_ff cell. It serves as a stimulus source for the cell and as a self-checking driver in flip-flop test structures.

---
 rtl/jk_excite_gen_if.sv | 19 +
 rtl/jk_excite_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/jk_excite_gen_if.sv
// Target handshake bundle for jk_excite_gen.
// master drives tgt_valid/tgt_bit; slave returns tgt_ready.
interface jk_excite_gen_if;
   logic tgt_valid;
   logic tgt_bit;
   logic tgt_ready;

   modport master (
      output tgt_valid,
      output tgt_bit,
      input  tgt_ready
   );

   modport slave (
      input  tgt_valid,
      input  tgt_bit,
      output tgt_ready
   );
endinterface

// File: rtl/jk_excite_gen.sv
// JK excitation generator: FIFO of target Q bits -> registered J/K,
// with a two-stage check of the flip-flop's Q feedback.
// Ports: clk, rst (async high), tgt (target handshake, slave),
//   drv_en (pop enable), q_fb (flop Q), j/k, busy, mismatch,
//   err_count (saturating), fifo_level.
// Optional macro JKGEN_ERR_STICKY_EN adds err_clr and makes
//   mismatch sticky until cleared.
module jk_excite_gen #(
   parameter int DEPTH   = 4,
   parameter bit DC_FILL = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   jk_excite_gen_if.slave         tgt,
   input  logic                   drv_en,
   input  logic                   q_fb,
`ifdef JKGEN_ERR_STICKY_EN
   input  logic                   err_clr,
`endif
   output logic                   j,
   output logic                   k,
   output logic                   busy,
   output logic                   mismatch,
   output logic [7:0]             err_count,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = DEPTH[AW:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_next;

   logic          r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          r_qpred;
   logic          r_chk1_v;
   logic          r_chk1_b;
   logic          r_chk2_v;
   logic          r_chk2_b;
   logic          r_j;
   logic          r_k;
   logic          r_mis;
   logic [7:0]    r_cnt;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_tgt;
   logic w_j;
   logic w_k;
   logic w_err;

   assign w_full  = (r_level == L_FULL);
   assign w_empty = (r_level == '0);
   // A full FIFO refuses pushes even if a pop frees a slot this edge.
   assign w_push  = tgt.tgt_valid && !w_full;
   assign w_pop   = drv_en && !w_empty;
   assign w_tgt   = r_mem[r_rptr];
   assign w_err   = r_chk2_v && (q_fb != r_chk2_b);

   // Inverse characteristic table; the unused term gets DC_FILL.
   always_comb begin
      w_j = 1'b0;
      w_k = 1'b0;
      if (!r_qpred) begin
         w_j = w_tgt;
         w_k = DC_FILL;
      end else begin
         w_j = DC_FILL;
         w_k = !w_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= tgt.tgt_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_j      <= 1'b0;
         r_k      <= 1'b0;
         r_qpred  <= 1'b0;
         r_chk1_v <= 1'b0;
         r_chk1_b <= 1'b0;
         r_chk2_v <= 1'b0;
         r_chk2_b <= 1'b0;
      end else begin
         r_chk2_v <= r_chk1_v;
         r_chk2_b <= r_chk1_b;
         if (w_pop) begin
            r_j      <= w_j;
            r_k      <= w_k;
            r_qpred  <= w_tgt;
            r_chk1_v <= 1'b1;
            r_chk1_b <= w_tgt;
         end else begin
            r_j      <= 1'b0;
            r_k      <= 1'b0;
            r_chk1_v <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mis <= 1'b0;
         r_cnt <= '0;
      end else begin
         if (w_err && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
`ifdef JKGEN_ERR_STICKY_EN
         // A new error outranks a clear on the same edge.
         if (w_err)        r_mis <= 1'b1;
         else if (err_clr) r_mis <= 1'b0;
`else
         r_mis <= w_err;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // DRAIN exits once no check will be pending after this edge:
   // chk1 clears without a pop and chk2 takes chk1's old value.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_pop) w_next = S_RUN;
         S_RUN:   if (!w_pop) w_next = S_DRAIN;
         S_DRAIN: begin
            if (w_pop)          w_next = S_RUN;
            else if (!r_chk1_v) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign tgt.tgt_ready = !w_full;
   assign j             = r_j;
   assign k             = r_k;
   assign busy          = (r_state != S_IDLE);
   assign mismatch      = r_mis;
   assign err_count     = r_cnt;
   assign fifo_level    = r_level;

endmodule
